mtpsa_digest_splitter: RTL and testbench

- Sits directly downstream of the egress SDNet wrapper.
- Consumes its packet stream, whose 304-bit TUSER carries the 48-bit SUME metadata plus a 256-bit digest in bits [303:48].
- Forwards the packet with a standard 128-bit SUME TUSER (digest field zeroed) toward the output queues.
- Diverts the digest of packets flagged send_dig_to_cpu into a small FIFO, presented on a separate AXIS-style digest port for the DMA/CPU path.

---
 rtl/mtpsa_digest_splitter.sv | 201 ++++++++++++++++++++
 tb/tb_mtpsa_digest_splitter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtpsa_digest_splitter.sv
// Splits the 304-bit egress TUSER into a standard 128-bit SUME TUSER for the packet
// stream and a {src_port, user_id, digest} record queued for the CPU digest port.
module mtpsa_digest_splitter #(
  parameter int C_AXIS_DATA_WIDTH    = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 304,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int DIGEST_WIDTH         = 256,
  parameter int DIG_FIFO_DEPTH       = 8
) (
  input  logic                              axis_aclk,
  input  logic                              axis_rst,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [DIGEST_WIDTH+15:0]          m_dig_tdata,
  output logic                              m_dig_tvalid,
  input  logic                              m_dig_tready,
  output logic [31:0]                       pkt_count,
  output logic [31:0]                       dig_count,
  output logic [31:0]                       dig_drop_count
);

  localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;
  localparam int DIG_W  = DIGEST_WIDTH + 16;
  localparam int PTR_W  = $clog2(DIG_FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PAD_W  = C_M_AXIS_TUSER_WIDTH - 48;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DIG_FIFO_DEPTH);

  // Only the 48-bit SUME metadata travels with a beat; the digest is split off on entry.
  typedef struct packed {
    logic [C_AXIS_DATA_WIDTH-1:0] data;
    logic [KEEP_W-1:0]            keep;
    logic                         last;
    logic [47:0]                  user;
  } beat_t;

  beat_t             in_beat_s;
  beat_t             main_beat_r, main_beat_s;
  beat_t             skid_beat_r, skid_beat_s;
  logic              main_valid_r, main_valid_s;
  logic              skid_valid_r, skid_valid_s;
  logic              tready_r;
  logic              in_hs_s;
  logic              out_hs_s;
  logic              sop_r;

  logic [DIG_W-1:0]  dig_mem_r [DIG_FIFO_DEPTH];
  logic [DIG_W-1:0]  push_data_s;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  fifo_count_r, fifo_count_s;
  logic              dig_valid_r;
  logic              push_req_s;
  logic              push_ok_s;
  logic              drop_s;
  logic              pop_s;

  logic [31:0]       pkt_count_r;
  logic [31:0]       dig_count_r;
  logic [31:0]       dig_drop_count_r;

  assign in_beat_s   = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser[47:0]};
  assign in_hs_s     = s_axis_tvalid && tready_r;
  assign out_hs_s    = main_valid_r && m_axis_tready;
  assign pop_s       = dig_valid_r && m_dig_tready;
  assign push_data_s = {s_axis_tuser[23:16], s_axis_tuser[47:40],
                        s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:48]};
  assign push_req_s  = in_hs_s && sop_r && s_axis_tuser[32];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok_s   = push_req_s && ((fifo_count_r < DEPTH_C) || pop_s);
  assign drop_s      = push_req_s && !push_ok_s;

  // Skid buffer next state: the skid entry only fills while the main entry is stalled.
  always_comb begin
    main_beat_s  = main_beat_r;
    main_valid_s = main_valid_r;
    skid_beat_s  = skid_beat_r;
    skid_valid_s = skid_valid_r;
    if (!main_valid_r || out_hs_s) begin
      if (skid_valid_r) begin
        main_beat_s  = skid_beat_r;
        main_valid_s = 1'b1;
        skid_beat_s  = in_beat_s;
        skid_valid_s = in_hs_s;
      end else begin
        main_beat_s  = in_beat_s;
        main_valid_s = in_hs_s;
        skid_valid_s = 1'b0;
      end
    end else begin
      if (in_hs_s) begin
        skid_beat_s  = in_beat_s;
        skid_valid_s = 1'b1;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end
  end

  // Skid buffer registers and the registered input-ready.
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      main_beat_r  <= '0;
      skid_beat_r  <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      tready_r     <= 1'b1;
    end else begin
      main_beat_r  <= main_beat_s;
      skid_beat_r  <= skid_beat_s;
      main_valid_r <= main_valid_s;
      skid_valid_r <= skid_valid_s;
      tready_r     <= !skid_valid_s;
    end
  end

  // Digest FIFO occupancy next state.
  always_comb begin
    fifo_count_s = fifo_count_r;
    case ({push_ok_s, pop_s})
      2'b10:   fifo_count_s = fifo_count_r + CNT_ONE;
      2'b01:   fifo_count_s = fifo_count_r - CNT_ONE;
      default: fifo_count_s = fifo_count_r;
    endcase
  end

  // Digest FIFO pointers, occupancy and the registered non-empty flag.
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      fifo_count_r <= CNT_ZERO;
      dig_valid_r  <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      fifo_count_r <= fifo_count_s;
      dig_valid_r  <= (fifo_count_s != CNT_ZERO);
    end
  end

  // Digest storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge axis_aclk) begin
    if (push_ok_s) begin
      dig_mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // Start-of-packet tracking and the free-running statistics counters.
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      sop_r            <= 1'b1;
      pkt_count_r      <= 32'd0;
      dig_count_r      <= 32'd0;
      dig_drop_count_r <= 32'd0;
    end else begin
      if (in_hs_s) begin
        sop_r <= s_axis_tlast;
      end
      if (out_hs_s && main_beat_r.last) begin
        pkt_count_r <= pkt_count_r + 32'd1;
      end
      if (push_ok_s) begin
        dig_count_r <= dig_count_r + 32'd1;
      end
      if (drop_s) begin
        dig_drop_count_r <= dig_drop_count_r + 32'd1;
      end
    end
  end

  assign s_axis_tready  = tready_r;
  assign m_axis_tdata   = main_beat_r.data;
  assign m_axis_tkeep   = main_beat_r.keep;
  assign m_axis_tlast   = main_beat_r.last;
  assign m_axis_tuser   = {{PAD_W{1'b0}}, main_beat_r.user};
  assign m_axis_tvalid  = main_valid_r;
  assign m_dig_tdata    = dig_mem_r[rd_ptr_r];
  assign m_dig_tvalid   = dig_valid_r;
  assign pkt_count      = pkt_count_r;
  assign dig_count      = dig_count_r;
  assign dig_drop_count = dig_drop_count_r;

endmodule

// File: tb/tb_mtpsa_digest_splitter.sv
// Self-checking bench: queue-based model of packet and digest flow, random and directed traffic.
module tb_mtpsa_digest_splitter;

  logic          axis_aclk = 1'b0;
  logic          axis_rst;
  logic [255:0]  s_axis_tdata;
  logic [31:0]   s_axis_tkeep;
  logic [303:0]  s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [255:0]  m_axis_tdata;
  logic [31:0]   m_axis_tkeep;
  logic [127:0]  m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [271:0]  m_dig_tdata;
  logic          m_dig_tvalid;
  logic          m_dig_tready;
  logic [31:0]   pkt_count;
  logic [31:0]   dig_count;
  logic [31:0]   dig_drop_count;

  mtpsa_digest_splitter dut (
    .axis_aclk(axis_aclk), .axis_rst(axis_rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_dig_tdata(m_dig_tdata), .m_dig_tvalid(m_dig_tvalid), .m_dig_tready(m_dig_tready),
    .pkt_count(pkt_count), .dig_count(dig_count), .dig_drop_count(dig_drop_count)
  );

  always #5 axis_aclk = ~axis_aclk;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
    logic [47:0]  u;
  } beat_t;

  beat_t        exp_q[$];
  logic [271:0] dig_q[$];
  logic         m_sop;
  logic [31:0]  m_pkt, m_dig, m_drop;
  int           checks = 0;
  int           errors = 0;
  int           stalls = 0;
  logic         mon_en = 1'b0;
  int           m_mode = 0;
  int           d_mode = 0;
  logic         d_manual = 1'b0;

  task automatic check(input string name, input logic [271:0] act, input logic [271:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sink readiness patterns, applied 2 time units after each rising edge.
  initial begin
    m_axis_tready = 1'b1;
    m_dig_tready  = 1'b1;
    forever begin
      @(posedge axis_aclk);
      #2;
      case (m_mode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = 1'($urandom_range(0, 1));
        2: m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'b0;
      endcase
      case (d_mode)
        0: m_dig_tready = 1'b1;
        1: m_dig_tready = 1'($urandom_range(0, 1));
        2: m_dig_tready = ~m_dig_tready;
        3: m_dig_tready = 1'b0;
        default: m_dig_tready = d_manual;
      endcase
    end
  end

  // Model and compare: state seen at a falling edge must match the model, then the
  // handshakes that will complete at the next rising edge are applied to the model.
  always @(negedge axis_aclk) begin
    if (mon_en) begin
      check("s_tready", 272'(s_axis_tready), 272'(exp_q.size() < 2));
      check("m_tvalid", 272'(m_axis_tvalid), 272'(exp_q.size() != 0));
      check("dig_tvalid", 272'(m_dig_tvalid), 272'(dig_q.size() != 0));
      check("pkt_count", 272'(pkt_count), 272'(m_pkt));
      check("dig_count", 272'(dig_count), 272'(m_dig));
      check("drop_count", 272'(dig_drop_count), 272'(m_drop));
      if (m_axis_tvalid && exp_q.size() > 0) begin
        check("m_tdata", 272'(m_axis_tdata), 272'(exp_q[0].d));
        check("m_tkeep", 272'(m_axis_tkeep), 272'(exp_q[0].k));
        check("m_tlast", 272'(m_axis_tlast), 272'(exp_q[0].l));
        check("m_tuser", 272'(m_axis_tuser), 272'({80'd0, exp_q[0].u}));
      end
      if (m_dig_tvalid && dig_q.size() > 0) begin
        check("dig_tdata", m_dig_tdata, dig_q[0]);
      end
      if (!s_axis_tready) stalls++;
    end
    if (axis_rst) begin
      exp_q.delete();
      dig_q.delete();
      m_sop = 1'b1;
      m_pkt = 32'd0;
      m_dig = 32'd0;
      m_drop = 32'd0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && exp_q.size() > 0) begin
        if (exp_q[0].l) m_pkt = m_pkt + 32'd1;
        void'(exp_q.pop_front());
      end
      if (m_dig_tvalid && m_dig_tready && dig_q.size() > 0) begin
        void'(dig_q.pop_front());
      end
      if (s_axis_tvalid && s_axis_tready) begin
        exp_q.push_back('{s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser[47:0]});
        if (m_sop && s_axis_tuser[32]) begin
          if (dig_q.size() < 8) begin
            dig_q.push_back({s_axis_tuser[23:16], s_axis_tuser[47:40], s_axis_tuser[303:48]});
            m_dig = m_dig + 32'd1;
          end else begin
            m_drop = m_drop + 32'd1;
          end
        end
        m_sop = s_axis_tlast;
      end
    end
  end

  function automatic logic [303:0] rand_tuser();
    logic [303:0] t;
    for (int i = 0; i < 19; i++) t[i*16 +: 16] = 16'($urandom);
    return t;
  endfunction

  function automatic logic [255:0] rand_data();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  // Present one beat (caller sits just after a rising edge) and hold until accepted.
  task automatic drive_beat(input logic [255:0] d, input logic [31:0] k, input logic l,
                            input logic [303:0] u);
    int   n;
    logic hs;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 200) begin
      @(negedge axis_aclk);
      hs = s_axis_tready;
      @(posedge axis_aclk);
      #1;
      n++;
    end
    if (!hs) check("input_handshake_timeout", 272'(hs), 272'(1'b1));
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic flag, input logic gaps);
    logic [303:0] u;
    for (int i = 0; i < len; i++) begin
      u = rand_tuser();
      u[32] = (i == 0) ? flag : 1'b1;
      drive_beat(rand_data(), $urandom, (i == len - 1), u);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge axis_aclk); #1; end
    end
  endtask

  task automatic do_reset();
    axis_rst      = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge axis_aclk);
    #1;
    axis_rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge axis_aclk); #1; end
  endtask

  task automatic wait_drain();
    int n = 0;
    m_mode = 0;
    d_mode = 0;
    while ((exp_q.size() != 0 || dig_q.size() != 0) && n < 300) begin
      @(posedge axis_aclk);
      n++;
    end
    #1;
    check("drain_timeout", 272'(n < 300), 272'(1'b1));
  endtask

  logic [303:0] u1;

  initial begin
    axis_rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tuser = '0;
    s_axis_tlast = 1'b0;
    idle(2);
    do_reset();
    mon_en = 1'b1;

    // Reset state.
    @(negedge axis_aclk);
    check("rst_s_tready", 272'(s_axis_tready), 272'(1'b1));
    check("rst_m_tvalid", 272'(m_axis_tvalid), 272'(1'b0));
    check("rst_dig_tvalid", 272'(m_dig_tvalid), 272'(1'b0));
    check("rst_pkt_count", 272'(pkt_count), 272'(32'd0));
    @(posedge axis_aclk); #1;

    // Single-beat flagged packet with pinned fields.
    u1 = rand_tuser();
    u1[32] = 1'b1;
    u1[47:40] = 8'h05;
    u1[23:16] = 8'h01;
    u1[303:48] = {32{8'hA5}};
    drive_beat(rand_data(), 32'hFFFF_FFFF, 1'b1, u1);
    @(negedge axis_aclk);
    check("t1_latency", 272'(m_axis_tvalid), 272'(1'b1));
    check("t1_tuser", 272'(m_axis_tuser), 272'({80'd0, u1[47:0]}));
    check("t1_dig", m_dig_tdata, {8'h01, 8'h05, {32{8'hA5}}});
    idle(3);
    @(negedge axis_aclk);
    check("t1_dig_count", 272'(dig_count), 272'(32'd1));
    check("t1_pkt_count", 272'(pkt_count), 272'(32'd1));

    // 4-beat flagged packet: later beats carry flag and digest bits that must be ignored.
    @(posedge axis_aclk); #1;
    do_reset();
    send_pkt(4, 1'b1, 1'b0);
    idle(4);
    @(negedge axis_aclk);
    check("t2_dig_count", 272'(dig_count), 272'(32'd1));
    check("t2_pkt_count", 272'(pkt_count), 272'(32'd1));

    // Unflagged 3-beat packet.
    @(posedge axis_aclk); #1;
    do_reset();
    send_pkt(3, 1'b0, 1'b1);
    idle(4);
    @(negedge axis_aclk);
    check("t3_dig_count", 272'(dig_count), 272'(32'd0));
    check("t3_pkt_count", 272'(pkt_count), 272'(32'd1));

    // Ten flagged packets into a blocked digest port, then push and pop while full.
    @(posedge axis_aclk); #1;
    do_reset();
    d_manual = 1'b0;
    d_mode = 4;
    for (int i = 0; i < 10; i++) send_pkt(1, 1'b1, 1'b0);
    idle(3);
    @(negedge axis_aclk);
    check("t4_dig_count", 272'(dig_count), 272'(32'd8));
    check("t4_drop_count", 272'(dig_drop_count), 272'(32'd2));
    check("t4_pkt_count", 272'(pkt_count), 272'(32'd10));
    @(posedge axis_aclk); #1;
    d_manual = 1'b1;
    send_pkt(1, 1'b1, 1'b0);
    d_manual = 1'b0;
    idle(3);
    @(negedge axis_aclk);
    check("t7_dig_count", 272'(dig_count), 272'(32'd9));
    check("t7_drop_count", 272'(dig_drop_count), 272'(32'd2));
    check("t7_dig_tvalid", 272'(m_dig_tvalid), 272'(1'b1));
    @(posedge axis_aclk); #1;
    wait_drain();

    // 16-beat packet against a toggling output ready.
    do_reset();
    stalls = 0;
    m_mode = 2;
    send_pkt(16, 1'b1, 1'b0);
    wait_drain();
    @(negedge axis_aclk);
    check("t5_stalled", 272'(stalls > 0), 272'(1'b1));
    check("t5_pkt_count", 272'(pkt_count), 272'(32'd1));
    @(posedge axis_aclk); #1;

    // Reset in the middle of a packet.
    d_mode = 4;
    d_manual = 1'b0;
    send_pkt(1, 1'b1, 1'b0);
    drive_beat(rand_data(), $urandom, 1'b0, rand_tuser() | 304'd1 << 32);
    drive_beat(rand_data(), $urandom, 1'b0, rand_tuser());
    do_reset();
    @(negedge axis_aclk);
    check("t6_m_tvalid", 272'(m_axis_tvalid), 272'(1'b0));
    check("t6_dig_tvalid", 272'(m_dig_tvalid), 272'(1'b0));
    check("t6_dig_count", 272'(dig_count), 272'(32'd0));
    check("t6_pkt_count", 272'(pkt_count), 272'(32'd0));
    check("t6_s_tready", 272'(s_axis_tready), 272'(1'b1));
    @(posedge axis_aclk); #1;
    send_pkt(1, 1'b1, 1'b0);
    idle(2);
    @(negedge axis_aclk);
    check("t6_sop_dig_count", 272'(dig_count), 272'(32'd1));
    @(posedge axis_aclk); #1;
    wait_drain();

    // Randomized traffic with random sink behaviour.
    for (int p = 0; p < 40; p++) begin
      m_mode = $urandom_range(0, 2);
      d_mode = $urandom_range(0, 3);
      send_pkt($urandom_range(1, 5), 1'($urandom_range(0, 1)), 1'b1);
    end
    wait_drain();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
